slave_reg: RTL and testbench
============================

# slave_reg

Bus responder for the parameterized communication bus: the target end of the valid/ready read/write handshake that the bus master drives. It decodes a 16-bit word address into a bank of 32-bit registers, commits writes, and returns read data. It inserts a programmable number of wait states before signalling completion with a one-cycle `ready` pulse. It sits on the slave side of the bus interconnect, one instance per register-mapped peripheral.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers, at least 1.
- `BASE_ADDR`, 16'h0010: byte address of register 0, 4-byte aligned.
- `WAIT_CYCLES`, 1: wait states between acceptance and `ready`, 0 to 15.

- `clk` in 1: single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `valid` in 1: the master has a request pending.
- `read` in 1: read request, qualified by `valid`.
- `write` in 1: write request, qualified by `valid`.
- `addr` in 16: byte address.
- `write_data` in 32: write payload.
- `read_data` out 32: read response data.
- `ready` out 1: transaction complete, pulsed for one cycle.
- `error` out 1: decode error, meaningful only while `ready`=1.

## Operation
- Reset state: all registers 0, state IDLE, wait counter 0, `ready`=0, `error`=0, `read_data`=32'h0.
- While `reset_n` is low, every output holds its reset value regardless of the clock.
- Decode:
  - Hit when `addr[1:0]`==0, `addr` ≥ `BASE_ADDR`, and `addr` < `BASE_ADDR`+4*`NUM_REGS`.
  - Register index = (`addr`−`BASE_ADDR`)>>2.
  - Index arithmetic is 16-bit unsigned; an `addr` below `BASE_ADDR` is a miss and never wraps to a hit.
- State machine:
  - IDLE: on `valid`=1 with exactly one of `read`/`write`, latch `addr`, `write_data`, the op and the hit flag.
    - Go to WAIT with counter=`WAIT_CYCLES`, or go directly to RESP when `WAIT_CYCLES`=0.
    - `valid`=1 with both or neither of `read`/`write` is ignored; stay in IDLE.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 1.
    - If `valid` drops during WAIT, abort to IDLE: no write, no `ready`.
  - RESP: `ready`=1 for exactly this one cycle, then IDLE.
- Write commit: a write hit updates the register at the edge that enters RESP.
- Read response: `read_data` loads at the edge that enters RESP and holds until the next read response.
  - Read hit: the register value.
  - Read miss: 32'h0.
- A write miss is dropped silently.
- Inputs are sampled only in IDLE and for the `valid` abort check. Changes to `addr`/`write_data` during WAIT are ignored.
- Back-to-back transactions: if `valid` is still high in the IDLE cycle after RESP, it starts a new transaction. A master must drop `valid`, or present a new request, on seeing `ready`.

## Timing
- Acceptance edge E (IDLE, `valid`=1). `ready` is high in the cycle after edge E+`WAIT_CYCLES`.
- Latency: `WAIT_CYCLES`+1 cycles from the sampled `valid` to `ready`.
- With `WAIT_CYCLES`=0, `ready` is seen high at edge E+1.
- Minimum transaction spacing: `WAIT_CYCLES`+2 cycles.
- `ready`, `error` and `read_data` are registered outputs; there is no combinational path from any input.
- Reset asserted mid-transaction: return immediately to IDLE, clear the registers, deassert `ready`. A write in flight is not committed.
- A read that follows a write to the same address returns the new value.

## Configuration
- `SLAVE_REG_ERR_EN` defined:
  - A miss (out of range or misaligned) completes with `error`=1 and `ready`=1 in the same cycle.
  - A read miss returns `read_data`=32'hBADADD00.
  - An illegal op (both or neither of `read`/`write` with `valid`=1) is accepted and completes with `error`=1.
- Not defined:
  - `error` is tied to 0.
  - A read miss returns 32'h0.
  - Illegal ops are ignored.

## Test plan
- Reset check: drive `reset_n`=0 asynchronously between edges. All outputs go to 0 immediately; a read of 16'h0010 after release returns 32'h0.
- Write/read, `WAIT_CYCLES`=1: write 32'hDEADBEEF to 16'h0010, then read 16'h0010.
  - `ready` arrives 2 cycles after each `valid`.
  - The read returns 32'hDEADBEEF.
- Boundary, `NUM_REGS`=16: write 32'h1 to 16'h004C (last register), then read 16'h0050 and 16'h000C.
  - 16'h004C reads back 32'h1.
  - 16'h0050 and 16'h000C are misses: 32'h0 with the macro off, 32'hBADADD00 with `error`=1 with it on.
- Abort: drop `valid` during WAIT of a write of 32'h5 to 16'h0014. No `ready` occurs, and a subsequent read of 16'h0014 returns 32'h0.
- Back-to-back, `WAIT_CYCLES`=0: hold `valid` with alternating write/read to 16'h0018 and 32'hA5A5A5A5.
  - `ready` pulses every 2 cycles.
  - The read returns 32'hA5A5A5A5.
- Mid-transaction reset: assert `reset_n`=0 in WAIT of a write of 32'h7 to 16'h0010. `ready` stays 0 and the register reads back 32'h0.

Source files
------------

// File: rtl/slave_reg.sv
// slave_reg: register-bank responder for the valid/ready bus.
//
// Decodes a 16-bit byte address into NUM_REGS 32-bit registers starting at BASE_ADDR.
// Writes are committed, and reads are answered, on the edge that enters the response
// state. WAIT_CYCLES wait states are inserted between acceptance and the one-cycle
// ready pulse.
//
// Optional feature macro: SLAVE_REG_ERR_EN
//   When defined, decode misses and illegal ops (both/neither of read/write) complete
//   with error=1, and read misses return 32'hBADADD00. Otherwise error is tied to 0,
//   read misses return 0 and illegal ops are ignored.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   valid       request pending
//   read/write  operation select, qualified by valid
//   addr        byte address
//   write_data  write payload
//   read_data   read response, held until the next read response
//   ready       one-cycle completion pulse
//   error       decode/illegal-op error, meaningful while ready=1
module slave_reg #(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [15:0] BASE_ADDR   = 16'h0010,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error
);

  localparam int unsigned IdxW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
`ifdef SLAVE_REG_ERR_EN
  localparam logic [31:0] MissData = 32'hBADADD00;
`else
  localparam logic [31:0] MissData = 32'h0;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    addr_q;
  logic [31:0]    wdata_q;
  logic           wr_q;
  logic           hit_q;
  logic [31:0]    regs_q [NUM_REGS];

  logic           is_idle;
  logic           legal_op;
  logic           start;
  logic           cur_ill;
  logic [15:0]    live_off;
  logic           hit_live;
  logic [15:0]    cur_addr;
  logic [15:0]    cur_off;
  logic [IdxW-1:0] cur_idx;
  logic           cur_hit;
  logic           cur_wr;
  logic [31:0]    cur_wdata;
  logic           resp_enter;
  logic           we;
  logic           re;
  logic           err_d;

  assign is_idle  = (state_q == StIdle);
  assign legal_op = valid && (read ^ write);

  // Misses below BASE_ADDR are rejected explicitly so the 16-bit subtraction can't wrap
  // into the register window.
  assign live_off = addr - BASE_ADDR;
  assign hit_live = (addr[1:0] == 2'b00) && (addr >= BASE_ADDR) &&
                    ({16'h0, live_off} < (NUM_REGS * 4));

  // With zero wait states the response is entered on the acceptance edge itself, so the
  // live inputs are used there; otherwise the latched request is used.
  assign cur_addr  = is_idle ? addr       : addr_q;
  assign cur_hit   = is_idle ? hit_live   : hit_q;
  assign cur_wr    = is_idle ? write      : wr_q;
  assign cur_wdata = is_idle ? write_data : wdata_q;
  assign cur_off   = cur_addr - BASE_ADDR;
  assign cur_idx   = cur_off[IdxW+1:2];

`ifdef SLAVE_REG_ERR_EN
  logic ill_q;
  assign start   = valid;
  assign cur_ill = is_idle ? (valid && !legal_op) : ill_q;
`else
  assign start   = legal_op;
  assign cur_ill = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (!valid) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = StResp;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign resp_enter = (state_d == StResp) && (state_q != StResp);
  assign we         = resp_enter && cur_wr && cur_hit && !cur_ill;
  assign re         = resp_enter && !cur_wr && !cur_ill;
`ifdef SLAVE_REG_ERR_EN
  assign err_d      = resp_enter && (cur_ill || !cur_hit);
`else
  assign err_d      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (is_idle && start) begin
        addr_q  <= addr;
        wdata_q <= write_data;
        wr_q    <= write;
        hit_q   <= hit_live;
      end
    end
  end

`ifdef SLAVE_REG_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ill_q <= 1'b0;
      error <= 1'b0;
    end else begin
      if (is_idle && start) ill_q <= !legal_op;
      error <= err_d;
    end
  end
`else
  assign error = err_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data <= 32'h0;
      ready     <= 1'b0;
    end else begin
      ready <= resp_enter;
      if (re) read_data <= cur_hit ? regs_q[cur_idx] : MissData;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'h0;
    end else if (we) begin
      regs_q[cur_idx] <= cur_wdata;
    end
  end

endmodule

// File: tb/tb_slave_reg.sv
// Scoreboard bench for slave_reg: one instance with one wait state, one with none.
module tb_slave_reg;

  localparam int W1 = 1;
`ifdef SLAVE_REG_ERR_EN
  localparam logic [31:0] MISS_D = 32'hBADADD00;
  localparam logic        MISS_E = 1'b1;
`else
  localparam logic [31:0] MISS_D = 32'h0;
  localparam logic        MISS_E = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v1, rd1, wr1, rdy1, err1;
  logic [15:0] a1;
  logic [31:0] wd1, rdata1;
  logic        v0, rd0, wr0, rdy0, err0;
  logic [15:0] a0;
  logic [31:0] wd0, rdata0;

  slave_reg #(.NUM_REGS(16), .BASE_ADDR(16'h0010), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset_n(reset_n), .valid(v1), .read(rd1), .write(wr1), .addr(a1),
    .write_data(wd1), .read_data(rdata1), .ready(rdy1), .error(err1)
  );

  slave_reg #(.NUM_REGS(16), .BASE_ADDR(16'h0010), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .valid(v0), .read(rd0), .write(wr0), .addr(a0),
    .write_data(wd0), .read_data(rdata0), .ready(rdy0), .error(err0)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        is_rd;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rdy1_cnt = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endfunction

  function automatic void push(int which, logic [31:0] d, logic e, logic is_rd, int c,
                               string nm);
    exp_t x;
    x.data = d; x.err = e; x.is_rd = is_rd; x.cyc = c; x.nm = nm;
    if (which == 1) q1.push_back(x);
    else q0.push_back(x);
  endfunction

  // Monitors: pop one expectation per ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rdy1 === 1'b1) begin
      rdy1_cnt++;
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut1 unexpected ready at cycle %0d: got ready=1, required 0", cyc);
      end else begin
        e = q1.pop_front();
        chk({e.nm, " ready cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.nm, " error"}, {31'h0, err1}, {31'h0, e.err});
        if (e.is_rd) chk({e.nm, " data"}, rdata1, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rdy0 === 1'b1) begin
      if (q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut0 unexpected ready at cycle %0d: got ready=1, required 0", cyc);
      end else begin
        e = q0.pop_front();
        chk({e.nm, " ready cycle"}, 32'(cyc), 32'(e.cyc));
        chk({e.nm, " error"}, {31'h0, err0}, {31'h0, e.err});
        if (e.is_rd) chk({e.nm, " data"}, rdata0, e.data);
      end
    end
  end

  // One transaction on dut1; called one time unit after a rising edge.
  task automatic t1(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d,
                    input logic [31:0] exp_d, input logic exp_e, input string nm);
    bit seen = 0;
    push(1, exp_d, exp_e, r && !w, cyc + 1 + W1, nm);
    v1 = 1'b1; rd1 = r; wr1 = w; a1 = a; wd1 = d;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (rdy1) seen = 1;
    end
    v1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: got no ready in 10 cycles, required ready", nm);
    end
    @(posedge clk); #1;
  endtask

  int base;
  int c;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    v1 = 0; rd1 = 0; wr1 = 0; a1 = 0; wd1 = 0;
    v0 = 0; rd0 = 0; wr0 = 0; a0 = 0; wd0 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {31'h0, rdy1}, 32'h0);
    chk("reset read_data", rdata1, 32'h0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read with one wait state.
    t1(1, 0, 16'h0010, 32'h0, 32'h0, 1'b0, "rd 0010 after reset");
    t1(0, 1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, "wr 0010");
    t1(1, 0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, "rd 0010");

    // Asynchronous reset between edges clears outputs immediately.
    #2 reset_n = 1'b0;
    #1;
    chk("async reset read_data", rdata1, 32'h0);
    chk("async reset ready", {31'h0, rdy1}, 32'h0);
    chk("async reset error", {31'h0, err1}, 32'h0);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    t1(1, 0, 16'h0010, 32'h0, 32'h0, 1'b0, "rd 0010 after async reset");

    // Boundary and misses.
    t1(0, 1, 16'h004C, 32'h1, 32'h0, 1'b0, "wr 004C");
    t1(1, 0, 16'h004C, 32'h0, 32'h1, 1'b0, "rd 004C");
    t1(1, 0, 16'h0050, 32'h0, MISS_D, MISS_E, "rd 0050 miss");
    t1(1, 0, 16'h000C, 32'h0, MISS_D, MISS_E, "rd 000C miss");
    t1(1, 0, 16'h0012, 32'h0, MISS_D, MISS_E, "rd 0012 misaligned");
    t1(0, 1, 16'h0050, 32'h99, 32'h0, MISS_E, "wr 0050 miss");
    t1(1, 0, 16'h004C, 32'h0, 32'h1, 1'b0, "rd 004C after miss write");

    // Illegal op: both read and write.
`ifdef SLAVE_REG_ERR_EN
    t1(1, 1, 16'h0010, 32'h3, 32'h0, 1'b1, "illegal op");
`else
    base = rdy1_cnt;
    v1 = 1'b1; rd1 = 1'b1; wr1 = 1'b1; a1 = 16'h0010; wd1 = 32'h3;
    repeat (3) @(posedge clk);
    #1 v1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("illegal op ignored", 32'(rdy1_cnt - base), 32'h0);
`endif
    t1(1, 0, 16'h0010, 32'h0, 32'h0, 1'b0, "rd 0010 after illegal op");

    // Abort: drop valid during the wait state.
    base = rdy1_cnt;
    v1 = 1'b1; wr1 = 1'b1; a1 = 16'h0014; wd1 = 32'h5;
    @(posedge clk); #1;
    v1 = 1'b0; wr1 = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("abort no ready", 32'(rdy1_cnt - base), 32'h0);
    t1(1, 0, 16'h0014, 32'h0, 32'h0, 1'b0, "rd 0014 after abort");

    // Reset asserted while a write waits.
    base = rdy1_cnt;
    v1 = 1'b1; wr1 = 1'b1; a1 = 16'h0010; wd1 = 32'h7;
    @(posedge clk); #1;
    #2 reset_n = 1'b0;
    v1 = 1'b0; wr1 = 1'b0;
    #1 chk("mid reset ready", {31'h0, rdy1}, 32'h0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("mid reset no ready", 32'(rdy1_cnt - base), 32'h0);
    t1(1, 0, 16'h0010, 32'h0, 32'h0, 1'b0, "rd 0010 after mid reset");

    // Back-to-back on the zero-wait instance, valid held high throughout.
    c = cyc;
    push(0, 32'h0, 1'b0, 1'b0, c + 1, "b2b wr A5");
    push(0, 32'hA5A5A5A5, 1'b0, 1'b1, c + 3, "b2b rd A5");
    push(0, 32'h0, 1'b0, 1'b0, c + 5, "b2b wr 5A");
    push(0, 32'h5A5A5A5A, 1'b0, 1'b1, c + 7, "b2b rd 5A");
    v0 = 1'b1; wr0 = 1'b1; rd0 = 1'b0; a0 = 16'h0018; wd0 = 32'hA5A5A5A5;
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 wr0 = 1'b1; rd0 = 1'b0; wd0 = 32'h5A5A5A5A;
    repeat (2) @(posedge clk);
    #1 wr0 = 1'b0; rd0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 v0 = 1'b0; rd0 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("dut1 queue drained", 32'(q1.size()), 32'h0);
    chk("dut0 queue drained", 32'(q0.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
